// File: rtl/dmadd_sequencer_if.sv
// Host-side handshake bundle for the DMADD job sequencer.
// Job start, item stream, result handshake and status all travel through it.
interface dmadd_sequencer_if;
  logic        job_start;
  logic [1:0]  job_op;
  logic        item_valid;
  logic        item_ready;
  logic [3:0]  item_index;
  logic [3:0]  item_data;
  logic        item_last;
  logic        abort;
  logic        res_valid;
  logic        res_ready;
  logic [11:0] res_value;
  logic        res_err;
  logic        busy;
  logic [7:0]  job_count;

  modport master (
    output job_start, job_op, item_valid, item_index, item_data, item_last,
           abort, res_ready,
    input  item_ready, res_valid, res_value, res_err, busy, job_count
  );

  modport slave (
    input  job_start, job_op, item_valid, item_index, item_data, item_last,
           abort, res_ready,
    output item_ready, res_valid, res_value, res_err, busy, job_count
  );
endinterface

// File: rtl/dmadd_sequencer.sv
// Job-level controller for one DMADD engine: reset, init, load and run phases,
// then capture of the 12-bit result. Every engine pin is driven from a flop.
module dmadd_sequencer #(
  parameter int CLR_CYCLES = 2,
  parameter int RUN_CYCLES = 17,
  parameter int MAX_ITEMS  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  dmadd_sequencer_if.slave        host,
  output logic                    eng_rst_n,
  output logic                    eng_run,
  output logic                    eng_load,
  output logic [1:0]              eng_insn,
  output logic [3:0]              eng_index,
  output logic [3:0]              eng_data,
  input  logic [7:0]              eng_out,
  input  logic [3:0]              eng_out_top
);

  typedef enum logic [2:0] {IDLE, CLEAR, INIT, LOAD, RUN, SETTLE, DONE} state_t;

  localparam logic [7:0] CLR_INIT = 8'(CLR_CYCLES - 1);
  localparam logic [7:0] RUN_INIT = 8'(RUN_CYCLES);
  localparam logic [4:0] MAX_CNT  = 5'(MAX_ITEMS);

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  item_cnt_q, item_cnt_d;
  logic [4:0]  item_cnt_inc;
  logic        item_ready_q, item_ready_d;
  logic        res_valid_q, res_valid_d;
  logic [11:0] res_value_q, res_value_d;
  logic        res_err_q, res_err_d;
  logic        busy_q, busy_d;
  logic [7:0]  job_count_q, job_count_d;
  logic        eng_rst_n_q, eng_rst_n_d;
  logic        eng_run_q, eng_run_d;
  logic        eng_load_q, eng_load_d;
  logic [1:0]  eng_insn_q, eng_insn_d;
  logic [3:0]  eng_index_q, eng_index_d;
  logic [3:0]  eng_data_q, eng_data_d;
  logic        accept;
  logic        aborting;

  assign accept       = (state_q == LOAD) && host.item_valid && item_ready_q;
  assign aborting     = host.abort && (state_q inside {CLEAR, INIT, LOAD, RUN, SETTLE});
  assign item_cnt_inc = item_cnt_q + 5'd1;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    item_cnt_d  = item_cnt_q;
    res_value_d = res_value_q;
    res_err_d   = res_err_q;
    job_count_d = job_count_q;
    eng_load_d  = 1'b0;
    eng_index_d = eng_index_q;
    eng_data_d  = eng_data_q;

    case (state_q)
      IDLE: begin
        if (host.job_start) begin
          if (host.job_op == 2'b11) begin
            res_value_d = 12'h000;
            res_err_d   = 1'b1;
            state_d     = DONE;
          end else begin
            op_d       = host.job_op;
            item_cnt_d = 5'd0;
            res_err_d  = 1'b0;
            cnt_d      = CLR_INIT;
            state_d    = CLEAR;
          end
        end
      end
      // MADD skips INIT: the engine reset already leaves it scanning downwards.
      CLEAR: begin
        if (cnt_q == 8'd0) state_d = (op_q == 2'b10) ? LOAD : INIT;
        else               cnt_d   = cnt_q - 8'd1;
      end
      INIT: state_d = LOAD;
      LOAD: begin
        if (accept) begin
          item_cnt_d  = item_cnt_inc;
          eng_load_d  = 1'b1;
          eng_index_d = host.item_index;
          eng_data_d  = host.item_data;
          if (host.item_last) begin
            state_d = RUN;
            cnt_d   = RUN_INIT;
          end else if (item_cnt_inc == MAX_CNT) begin
            state_d   = RUN;
            cnt_d     = RUN_INIT;
            res_err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (cnt_q == 8'd0) state_d = SETTLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      SETTLE: begin
        res_value_d = {eng_out_top, eng_out};
        state_d     = DONE;
      end
      DONE: begin
        if (res_valid_q && host.res_ready) begin
          job_count_d = job_count_q + 8'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over any item accept or capture decided above.
    if (aborting) begin
      state_d     = IDLE;
      eng_load_d  = 1'b0;
      eng_index_d = eng_index_q;
      eng_data_d  = eng_data_q;
      res_value_d = res_value_q;
      res_err_d   = res_err_q;
    end

    // The first RUN cycle carries the final load pulse, so run starts after it.
    eng_run_d    = (state_q == RUN) && (state_d == RUN) && (cnt_q != 8'd0);
    eng_rst_n_d  = !((state_d == CLEAR) || aborting);
    item_ready_d = (state_d == LOAD);
    busy_d       = (state_d != IDLE);
    res_valid_d  = (state_d == DONE);
    eng_insn_d   = (state_d inside {INIT, LOAD, RUN}) ? op_q : eng_insn_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      op_q         <= 2'b00;
      cnt_q        <= 8'd0;
      item_cnt_q   <= 5'd0;
      item_ready_q <= 1'b0;
      res_valid_q  <= 1'b0;
      res_value_q  <= 12'h000;
      res_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      job_count_q  <= 8'd0;
      eng_rst_n_q  <= 1'b0;
      eng_run_q    <= 1'b0;
      eng_load_q   <= 1'b0;
      eng_insn_q   <= 2'b00;
      eng_index_q  <= 4'd0;
      eng_data_q   <= 4'd0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      item_cnt_q   <= item_cnt_d;
      item_ready_q <= item_ready_d;
      res_valid_q  <= res_valid_d;
      res_value_q  <= res_value_d;
      res_err_q    <= res_err_d;
      busy_q       <= busy_d;
      job_count_q  <= job_count_d;
      eng_rst_n_q  <= eng_rst_n_d;
      eng_run_q    <= eng_run_d;
      eng_load_q   <= eng_load_d;
      eng_insn_q   <= eng_insn_d;
      eng_index_q  <= eng_index_d;
      eng_data_q   <= eng_data_d;
    end
  end

  assign host.item_ready = item_ready_q;
  assign host.res_valid  = res_valid_q;
  assign host.res_value  = res_value_q;
  assign host.res_err    = res_err_q;
  assign host.busy       = busy_q;
  assign host.job_count  = job_count_q;
  assign eng_rst_n       = eng_rst_n_q;
  assign eng_run         = eng_run_q;
  assign eng_load        = eng_load_q;
  assign eng_insn        = eng_insn_q;
  assign eng_index       = eng_index_q;
  assign eng_data        = eng_data_q;

endmodule

// File: tb/tb_dmadd_sequencer.sv
// Directed bench for dmadd_sequencer with a tiny min/max/sum engine stand-in.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_dmadd_sequencer;
  logic clk = 1'b0;
  logic rst;

  dmadd_sequencer_if hif();

  logic        eng_rst_n, eng_run, eng_load;
  logic [1:0]  eng_insn;
  logic [3:0]  eng_index, eng_data;
  logic [7:0]  eng_out;
  logic [3:0]  eng_out_top;

  int checks = 0;
  int errors = 0;
  int cyc = 0, load_cnt = 0, run_cnt = 0, rstlow_cnt = 0, valid_cnt = 0;

  logic [3:0]  mdl_min, mdl_max;
  logic [11:0] mdl_sum;
  logic        mdl_ran;

  always #5 clk = ~clk;

  dmadd_sequencer #(
    .CLR_CYCLES(2),
    .RUN_CYCLES(17),
    .MAX_ITEMS (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .host       (hif.slave),
    .eng_rst_n  (eng_rst_n),
    .eng_run    (eng_run),
    .eng_load   (eng_load),
    .eng_insn   (eng_insn),
    .eng_index  (eng_index),
    .eng_data   (eng_data),
    .eng_out    (eng_out),
    .eng_out_top(eng_out_top)
  );

  // Engine stand-in: result only becomes meaningful once it has been run.
  always @(posedge clk) begin
    if (!eng_rst_n) begin
      mdl_min <= 4'hF;
      mdl_max <= 4'h0;
      mdl_sum <= 12'h000;
      mdl_ran <= 1'b0;
    end else begin
      if (eng_load) begin
        if (eng_index < mdl_min) mdl_min <= eng_index;
        if (eng_index > mdl_max) mdl_max <= eng_index;
        mdl_sum <= mdl_sum + 12'(eng_data);
      end
      if (eng_run) mdl_ran <= 1'b1;
    end
  end

  always_comb begin
    eng_out     = 8'hEE;
    eng_out_top = 4'hE;
    if (mdl_ran) begin
      case (eng_insn)
        2'b00:   begin eng_out = {4'h0, mdl_min}; eng_out_top = 4'h0; end
        2'b01:   begin eng_out = {4'h0, mdl_max}; eng_out_top = 4'h0; end
        default: begin eng_out = mdl_sum[7:0];    eng_out_top = mdl_sum[11:8]; end
      endcase
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (eng_load)      load_cnt   <= load_cnt + 1;
    if (eng_run)       run_cnt    <= run_cnt + 1;
    if (!eng_rst_n)    rstlow_cnt <= rstlow_cnt + 1;
    if (hif.res_valid) valid_cnt  <= valid_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic [1:0] op, input logic iv,
                               input logic [3:0] idx, input logic [3:0] dat,
                               input logic last, input logic ab, input logic rr);
    hif.job_start  = start;
    hif.job_op     = op;
    hif.item_valid = iv;
    hif.item_index = idx;
    hif.item_data  = dat;
    hif.item_last  = last;
    hif.abort      = ab;
    hif.res_ready  = rr;
    @(negedge clk);
  endtask

  task automatic idleCycle(input logic rr);
    applyStimulus(1'b0, 2'b00, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, rr);
  endtask

  task automatic sendItem(input logic [3:0] idx, input logic [3:0] dat, input logic last);
    int waited = 0;
    while (!hif.item_ready && waited < 40) begin
      idleCycle(1'b0);
      waited++;
    end
    if (!hif.item_ready) checkOutput("item_ready_timeout", hif.item_ready, 1);
    else applyStimulus(1'b0, 2'b00, 1'b1, idx, dat, last, 1'b0, 1'b0);
  endtask

  task automatic waitValid(input string tag);
    int waited = 0;
    while (!hif.res_valid && waited < 100) begin
      idleCycle(1'b0);
      waited++;
    end
    if (!hif.res_valid) checkOutput(tag, hif.res_valid, 1);
  endtask

  task automatic handshake();
    idleCycle(1'b1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s_load, s_run, s_rst, s_valid, c0, bad, w;
    rst = 1'b1;
    hif.job_start = 1'b0; hif.job_op = 2'b00; hif.item_valid = 1'b0;
    hif.item_index = 4'd0; hif.item_data = 4'd0; hif.item_last = 1'b0;
    hif.abort = 1'b0; hif.res_ready = 1'b0;
    repeat (2) @(negedge clk);

    checkOutput("rst_busy", hif.busy, 0);
    checkOutput("rst_eng_rst_n", eng_rst_n, 0);
    checkOutput("rst_res_valid", hif.res_valid, 0);
    checkOutput("rst_item_ready", hif.item_ready, 0);
    checkOutput("rst_job_count", hif.job_count, 0);
    checkOutput("rst_eng_run", eng_run, 0);
    rst = 1'b0;
    idleCycle(1'b0);
    checkOutput("post_rst_eng_rst_n", eng_rst_n, 1);

    // MIN with two items
    s_load = load_cnt; s_run = run_cnt; c0 = cyc;
    applyStimulus(1'b1, 2'b00, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("min_busy", hif.busy, 1);
    sendItem(4'd5, 4'd0, 1'b0);
    sendItem(4'd9, 4'd0, 1'b1);
    waitValid("min_timeout");
    checkOutput("min_latency", cyc - c0, 25);
    checkOutput("min_loads", load_cnt - s_load, 2);
    checkOutput("min_runs", run_cnt - s_run, 17);
    checkOutput("min_value", hif.res_value, 12'h005);
    checkOutput("min_err", hif.res_err, 0);
    handshake();
    checkOutput("min_job_count", hif.job_count, 1);
    checkOutput("min_valid_clr", hif.res_valid, 0);
    checkOutput("min_idle", hif.busy, 0);

    // MAX with two items
    s_rst = rstlow_cnt;
    applyStimulus(1'b1, 2'b01, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    sendItem(4'd5, 4'd0, 1'b0);
    sendItem(4'd9, 4'd0, 1'b1);
    waitValid("max_timeout");
    checkOutput("max_value", hif.res_value, 12'h009);
    checkOutput("max_rst_low", rstlow_cnt - s_rst, 2);
    handshake();
    checkOutput("max_job_count", hif.job_count, 2);

    // Illegal op
    s_load = load_cnt; s_run = run_cnt; s_rst = rstlow_cnt;
    applyStimulus(1'b1, 2'b11, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("ill_valid", hif.res_valid, 1);
    checkOutput("ill_value", hif.res_value, 12'h000);
    checkOutput("ill_err", hif.res_err, 1);
    checkOutput("ill_busy", hif.busy, 1);
    repeat (3) idleCycle(1'b0);
    handshake();
    checkOutput("ill_loads", load_cnt - s_load, 0);
    checkOutput("ill_runs", run_cnt - s_run, 0);
    checkOutput("ill_rst_low", rstlow_cnt - s_rst, 0);
    checkOutput("ill_job_count", hif.job_count, 3);

    // MADD overflow: sixteen items, none marked last
    s_load = load_cnt; s_run = run_cnt;
    applyStimulus(1'b1, 2'b10, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) sendItem(4'(i), 4'(i), 1'b0);
    checkOutput("ovf_ready", hif.item_ready, 0);
    checkOutput("ovf_busy", hif.busy, 1);
    waitValid("ovf_timeout");
    checkOutput("ovf_err", hif.res_err, 1);
    checkOutput("ovf_value", hif.res_value, 12'h078);
    checkOutput("ovf_loads", load_cnt - s_load, 16);
    checkOutput("ovf_runs", run_cnt - s_run, 17);
    handshake();
    checkOutput("ovf_job_count", hif.job_count, 4);

    // Abort in LOAD after three items, colliding with a last item
    s_load = load_cnt; s_run = run_cnt; s_rst = rstlow_cnt; s_valid = valid_cnt;
    applyStimulus(1'b1, 2'b00, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    sendItem(4'd7, 4'd0, 1'b0);
    sendItem(4'd3, 4'd0, 1'b0);
    sendItem(4'd8, 4'd0, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b1, 4'd2, 4'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("abt_busy", hif.busy, 0);
    checkOutput("abt_eng_rst_n", eng_rst_n, 0);
    checkOutput("abt_ready", hif.item_ready, 0);
    checkOutput("abt_load", eng_load, 0);
    idleCycle(1'b0);
    checkOutput("abt_eng_rst_n_rel", eng_rst_n, 1);
    repeat (30) idleCycle(1'b0);
    checkOutput("abt_no_valid", valid_cnt - s_valid, 0);
    checkOutput("abt_no_run", run_cnt - s_run, 0);
    checkOutput("abt_loads", load_cnt - s_load, 3);
    checkOutput("abt_rst_low", rstlow_cnt - s_rst, 3);
    checkOutput("abt_job_count", hif.job_count, 4);

    // MAX single item, then hold off the result for ten cycles
    c0 = cyc;
    applyStimulus(1'b1, 2'b01, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    sendItem(4'd3, 4'd0, 1'b1);
    waitValid("hold_timeout");
    checkOutput("hold_latency", cyc - c0, 24);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 2'b00, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      if (hif.res_valid !== 1'b1 || hif.res_value !== 12'h003) bad++;
    end
    checkOutput("hold_stable", bad, 0);
    checkOutput("hold_value", hif.res_value, 12'h003);
    applyStimulus(1'b1, 2'b00, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("hold_idle", hif.busy, 0);
    checkOutput("hold_job_count", hif.job_count, 5);
    idleCycle(1'b0);
    checkOutput("hold_start_ignored", hif.busy, 0);

    // Asynchronous reset in the middle of RUN
    applyStimulus(1'b1, 2'b00, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    sendItem(4'd4, 4'd0, 1'b1);
    w = 0;
    while (!eng_run && w < 40) begin
      idleCycle(1'b0);
      w++;
    end
    if (!eng_run) checkOutput("run_timeout", eng_run, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_rst_run", eng_run, 0);
    checkOutput("mid_rst_busy", hif.busy, 0);
    checkOutput("mid_rst_eng_rst_n", eng_rst_n, 0);
    checkOutput("mid_rst_job_count", hif.job_count, 0);
    @(negedge clk);
    rst = 1'b0;
    idleCycle(1'b0);
    checkOutput("mid_rst_rel", eng_rst_n, 1);
    checkOutput("mid_rst_idle", hif.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmadd_sequencer.md
Name: dmadd_sequencer

Overview:
- Job-level controller for the DMADD min/max/multi-add engine: sequences engine reset, initialise, load and run phases, then captures the engine's 12-bit result.
- Sits between a host (job start, item stream, result handshake) and one DMADD instance; drives every DMADD input pin from registers.

Parameters:
CLR_CYCLES, 2, cycles eng_rst_n held low at job start (min 1)
RUN_CYCLES, 17, cycles eng_run held high per job (min 1, max 255)
MAX_ITEMS, 16, item count that forces end of load phase (1..16)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
job_start  in  1  start pulse, sampled only in IDLE
job_op  in  2  00 MIN, 01 MAX, 10 MADD, 11 illegal
item_valid  in  1  item present
item_ready  out  1  item accepted when valid&ready
item_index  in  4  item target index
item_data  in  4  item data (MADD only)
item_last  in  1  final item of job
abort  in  1  cancel current job
res_valid  out  1  result available
res_ready  in  1  host takes result
res_value  out  12  captured {eng_out_top, eng_out}
res_err  out  1  illegal op or item overflow
busy  out  1  state != IDLE
job_count  out  8  completed result handshakes, wraps 255->0
eng_rst_n  out  1  DMADD reset (active low)
eng_run  out  1  DMADD run
eng_load  out  1  DMADD load
eng_insn  out  2  DMADD insn
eng_index  out  4  DMADD index
eng_data  out  4  DMADD data
eng_out  in  8  DMADD out
eng_out_top  in  4  DMADD out_top

Behaviour:
- rst high (async): state IDLE; eng_rst_n=0 while rst high, 1 on first clk after release; all other outputs 0; counters 0.
- All outputs registered; engine pins change one cycle after the decision.
- IDLE: item_ready=0, eng_load=eng_run=0, eng_insn holds last op. job_start with op 00/01/10: latch op, item counter=0, res_err=0 -> CLEAR. job_start with op 11: res_value=0, res_err=1 -> DONE, no engine activity. job_start outside IDLE ignored.
- CLEAR: eng_rst_n=0 for exactly CLR_CYCLES cycles -> INIT (op 00/01) or LOAD (op 10; engine reset already sets descending scan).
- INIT: one cycle, eng_insn=op, load=0, run=0 -> LOAD.
- LOAD: item_ready=1. Accepted item -> next cycle eng_load=1, eng_index/eng_data=item fields, eng_insn=op; cycles without accept drive eng_load=0, run=0, insn=op. Item counter increments per accept. Accept with item_last -> RUN after that load pulse. MAX_ITEMS-th accept without item_last -> RUN, res_err=1; item_ready drops same cycle.
- RUN: eng_run=1, eng_insn=op for exactly RUN_CYCLES cycles (8-bit down-counter), then eng_run=0 -> SETTLE.
- SETTLE: one cycle, engine idle; at end, res_value <= {eng_out_top, eng_out} -> DONE.
- DONE: res_valid=1, res_value/res_err stable until res_valid&res_ready; that cycle job_count+1, res_valid cleared next cycle -> IDLE. job_start in handshake cycle ignored.
- abort in CLEAR/INIT/LOAD/RUN/SETTLE: next state IDLE, eng_rst_n=0 for one cycle, eng_load=eng_run=0, item_ready=0, no result, job_count unchanged. abort in DONE or IDLE ignored. abort beats item accept and item_last in same cycle.
- busy=1 in every state except IDLE.
- Minimum job latency (MIN, 1 item, no stalls): start -> res_valid = CLR_CYCLES + 1 + 2 + RUN_CYCLES + 2 cycles.

Test Plan:
- MIN, items idx 5 then 9 (last) -> exactly 2 eng_load pulses, 17 eng_run cycles, res_value=0x005, res_err=0, job_count=1.
- MAX, items idx 5, 9 (last) -> res_value=0x009; eng_rst_n low exactly 2 cycles after start.
- job_op=11 -> res_valid with res_value=0, res_err=1, eng_rst_n/load/run never toggle.
- 16 items, no item_last -> item_ready low after 16th accept, RUN entered, res_err=1.
- abort during LOAD after 3 items -> IDLE next cycle, single-cycle eng_rst_n=0, no res_valid, job_count unchanged.
- res_ready held low 10 cycles in DONE -> res_value stable, job_start ignored; rst asserted mid-RUN -> eng_run=0, busy=0 immediately.
